// File: rtl/hdmi_tester_pkg.sv
// -----------------------------------------------------------------------------
// hdmi_tester_pkg
// Shared types and constants for the HDMI tester video path.
//   CNT_W     : width of the sync generator pixel counters
//   pattern_t : test pattern selector encoding
//   rgb_t     : 24-bit pixel, one byte per channel
//   expand()  : turns a single colour bit into a full-scale channel value
// -----------------------------------------------------------------------------
package hdmi_tester_pkg;

  localparam int CNT_W = 10;

  typedef enum logic [1:0] {
    PAT_BARS     = 2'd0,
    PAT_CHECKER  = 2'd1,
    PAT_GRADIENT = 2'd2,
    PAT_BOX      = 2'd3
  } pattern_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic logic [7:0] expand(input logic bit_in);
    return bit_in ? 8'hFF : 8'h00;
  endfunction

endpackage

// File: rtl/hdmi_box_mover.sv
// -----------------------------------------------------------------------------
// hdmi_box_mover
// Position and direction of the bouncing box. Both axes move by BOX_STEP on
// every frame-start strobe and bounce off 0 and ACTIVE-BOX_SIZE.
// Ports:
//   clk, rst_n        : pixel clock, asynchronous active-low reset
//   i_fs              : frame-start strobe (one cycle)
//   o_box_x, o_box_y  : top-left corner of the box; during the i_fs cycle this
//                       is already the updated position so pixel (0,0) of the
//                       new frame sees the new placement
// -----------------------------------------------------------------------------
module hdmi_box_mover
  import hdmi_tester_pkg::*;
#(
  parameter int H_ACTIVE = 1000,
  parameter int V_ACTIVE = 766,
  parameter int BOX_SIZE = 64,
  parameter int BOX_STEP = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_fs,
  output logic [CNT_W-1:0] o_box_x,
  output logic [CNT_W-1:0] o_box_y
);

  logic [1:0][CNT_W-1:0] w_eff;

  // Axis 0 is x, axis 1 is y; the logic is identical apart from the bound.
  for (genvar gi = 0; gi < 2; gi++) begin : g_axis
    localparam logic [CNT_W:0] BOUND =
      (CNT_W+1)'((gi == 0) ? (H_ACTIVE - BOX_SIZE) : (V_ACTIVE - BOX_SIZE));
    localparam logic [CNT_W:0] STEP = (CNT_W+1)'(BOX_STEP);

    logic [CNT_W-1:0] r_pos;
    logic             r_dir;      // 0: increasing, 1: decreasing
    logic [CNT_W:0]   w_pos_ext;
    logic [CNT_W:0]   w_inc;
    logic [CNT_W-1:0] w_next;
    logic             w_dir_next;

    assign w_pos_ext = {1'b0, r_pos};

    always_comb begin
      w_inc      = w_pos_ext + STEP;
      w_next     = w_inc[CNT_W-1:0];
      w_dir_next = r_dir;
      if (!r_dir) begin
        // Overshooting the far edge clamps onto it and turns around.
        if (w_inc > BOUND) begin
          w_next     = BOUND[CNT_W-1:0];
          w_dir_next = 1'b1;
        end
      end else begin
        if (w_pos_ext < STEP) begin
          w_next     = '0;
          w_dir_next = 1'b0;
        end else begin
          w_next = r_pos - STEP[CNT_W-1:0];
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_pos <= '0;
        r_dir <= 1'b0;
      end else if (i_fs) begin
        r_pos <= w_next;
        r_dir <= w_dir_next;
      end
    end

    assign w_eff[gi] = i_fs ? w_next : r_pos;
  end

  assign o_box_x = w_eff[0];
  assign o_box_y = w_eff[1];

endmodule

// File: rtl/hdmi_pattern_gen.sv
// -----------------------------------------------------------------------------
// hdmi_pattern_gen
// Test pattern generator placed after the HV sync generator. Two-stage
// pipeline: stage 1 registers the counters, de, syncs and the frame-start
// strobe; stage 2 registers RGB together with the delayed de/syncs, so every
// output lags its input sample by exactly two clocks.
// Ports:
//   clk, rst_n                 : pixel clock, asynchronous active-low reset
//   counter_x, counter_y       : pixel position from the sync generator
//   in_display                 : display-enable from the sync generator
//   h_sync_in, v_sync_in       : active-low syncs
//   pattern_next               : one-cycle request to move to the next pattern
//   red, green, blue           : pixel output
//   h_sync_out, v_sync_out     : syncs re-aligned to RGB (active-low)
//   de_out                     : display-enable re-aligned to RGB
//   pattern_sel                : pattern currently being drawn
//   frame_count                : completed frames, wraps at 16 bits
// Build option: PATTERN_AUTO_CYCLE_EN adds an automatic advance every
// AUTO_FRAMES frame starts on top of the manual request.
// -----------------------------------------------------------------------------
module hdmi_pattern_gen
  import hdmi_tester_pkg::*;
#(
  parameter int H_ACTIVE    = 1000,
  parameter int V_ACTIVE    = 766,
  parameter int BOX_SIZE    = 64,
  parameter int BOX_STEP    = 2,
  parameter int AUTO_FRAMES = 120
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] counter_x,
  input  logic [CNT_W-1:0] counter_y,
  input  logic             in_display,
  input  logic             h_sync_in,
  input  logic             v_sync_in,
  input  logic             pattern_next,
  output logic [7:0]       red,
  output logic [7:0]       green,
  output logic [7:0]       blue,
  output logic             h_sync_out,
  output logic             v_sync_out,
  output logic             de_out,
  output logic [1:0]       pattern_sel,
  output logic [15:0]      frame_count
);

  // ---------------- stage 1 ----------------
  logic [CNT_W-1:0] r_x1, r_y1;
  logic             r_de1, r_hs1, r_vs1, r_fs1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x1  <= '0;
      r_y1  <= '0;
      r_de1 <= 1'b0;
      r_hs1 <= 1'b1;
      r_vs1 <= 1'b1;
      r_fs1 <= 1'b0;
    end else begin
      r_x1  <= counter_x;
      r_y1  <= counter_y;
      r_de1 <= in_display;
      r_hs1 <= h_sync_in;
      r_vs1 <= v_sync_in;
      r_fs1 <= (counter_x == '0) && (counter_y == '0);
    end
  end

  // ---------------- pattern selection ----------------
  pattern_t    r_sel;
  logic        r_pending;
  logic [15:0] r_frame_cnt;
  logic        w_manual, w_adv;
  pattern_t    w_sel_inc, w_sel_eff;

  // A request that arrives exactly on the frame-start cycle counts as well.
  assign w_manual  = r_pending | pattern_next;
  assign w_sel_inc = pattern_t'(r_sel + 2'd1);

`ifdef PATTERN_AUTO_CYCLE_EN
  localparam int AUTO_W = $clog2(AUTO_FRAMES + 1);
  logic [AUTO_W-1:0] r_auto_cnt;
  logic              w_auto_wrap;

  assign w_auto_wrap = (r_auto_cnt == AUTO_W'(AUTO_FRAMES - 1));
  assign w_adv       = w_manual | w_auto_wrap;

  // A manual advance restarts the auto interval.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_auto_cnt <= '0;
    end else if (r_fs1) begin
      r_auto_cnt <= w_adv ? '0 : r_auto_cnt + 1'b1;
    end
  end
`else
  logic w_auto_unused;
  assign w_auto_unused = (AUTO_FRAMES != 0);
  assign w_adv         = w_manual;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel       <= PAT_BARS;
      r_pending   <= 1'b0;
      r_frame_cnt <= '0;
    end else if (r_fs1) begin
      if (w_adv) r_sel <= w_sel_inc;
      r_pending   <= 1'b0;
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end else if (pattern_next) begin
      r_pending <= 1'b1;
    end
  end

  // Pixel (0,0) is drawn with the selection that takes effect at this start.
  assign w_sel_eff = (r_fs1 && w_adv) ? w_sel_inc : r_sel;

  // ---------------- box ----------------
  logic [CNT_W-1:0] w_box_x, w_box_y;

  hdmi_box_mover #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .BOX_SIZE (BOX_SIZE),
    .BOX_STEP (BOX_STEP)
  ) u_box_mover (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_fs    (r_fs1),
    .o_box_x (w_box_x),
    .o_box_y (w_box_y)
  );

  // One extra bit so box_x + BOX_SIZE cannot wrap.
  logic [CNT_W:0] w_x_ext, w_y_ext, w_bx_ext, w_by_ext;
  logic           w_in_box;

  assign w_x_ext  = {1'b0, r_x1};
  assign w_y_ext  = {1'b0, r_y1};
  assign w_bx_ext = {1'b0, w_box_x};
  assign w_by_ext = {1'b0, w_box_y};
  assign w_in_box = (w_x_ext >= w_bx_ext) && (w_x_ext < w_bx_ext + (CNT_W+1)'(BOX_SIZE)) &&
                    (w_y_ext >= w_by_ext) && (w_y_ext < w_by_ext + (CNT_W+1)'(BOX_SIZE));

  // ---------------- stage 2 ----------------
  rgb_t w_rgb;

  always_comb begin
    w_rgb = '0;
    if (r_de1) begin
      case (w_sel_eff)
        PAT_BARS: begin
          w_rgb.r = expand(r_x1[CNT_W-1]);
          w_rgb.g = expand(r_x1[CNT_W-2]);
          w_rgb.b = expand(r_x1[CNT_W-3]);
        end
        PAT_CHECKER: begin
          w_rgb.r = expand(r_x1[5] ^ r_y1[5]);
          w_rgb.g = expand(r_x1[5] ^ r_y1[5]);
          w_rgb.b = expand(r_x1[5] ^ r_y1[5]);
        end
        PAT_GRADIENT: begin
          w_rgb.r = r_x1[CNT_W-1:2];
          w_rgb.g = r_y1[CNT_W-1:2];
          w_rgb.b = 8'h80;
        end
        default: begin
          w_rgb.r = expand(w_in_box);
          w_rgb.g = expand(w_in_box);
          w_rgb.b = 8'hFF;
        end
      endcase
    end
  end

  rgb_t r_rgb2;
  logic r_de2, r_hs2, r_vs2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb2 <= '0;
      r_de2  <= 1'b0;
      r_hs2  <= 1'b1;
      r_vs2  <= 1'b1;
    end else begin
      r_rgb2 <= w_rgb;
      r_de2  <= r_de1;
      r_hs2  <= r_hs1;
      r_vs2  <= r_vs1;
    end
  end

  assign red         = r_rgb2.r;
  assign green       = r_rgb2.g;
  assign blue        = r_rgb2.b;
  assign de_out      = r_de2;
  assign h_sync_out  = r_hs2;
  assign v_sync_out  = r_vs2;
  assign pattern_sel = r_sel;
  assign frame_count = r_frame_cnt;

endmodule

// File: doc/hdmi_pattern_gen.md
Name: hdmi_pattern_gen

Overview:
- Sits directly downstream of the HV sync generator in the HDMI tester.
- Consumes its pixel counters, display-enable and active-low syncs, and produces 24-bit RGB test patterns with syncs and display-enable re-aligned.
- Four selectable patterns. The selection changes only at frame boundaries. A bouncing box is animated once per frame.

Parameters:
- H_ACTIVE, 1000: active pixels per line; also the right bound for the box.
- V_ACTIVE, 766: active lines per frame; also the bottom bound for the box.
- BOX_SIZE, 64: box edge in pixels.
- BOX_STEP, 2: box movement per frame on each axis, in pixels.
- AUTO_FRAMES, 120: frames per pattern in auto-cycle mode.

Ports:
- clk  in  1  pixel clock, same clock as the sync generator.
- rst_n  in  1  asynchronous active-low reset.
- counter_x  in  10  pixel column from the sync generator.
- counter_y  in  10  pixel row from the sync generator.
- in_display  in  1  display-area flag from the sync generator.
- h_sync_in  in  1  active-low hsync.
- v_sync_in  in  1  active-low vsync.
- pattern_next  in  1  single-cycle pulse (already debounced): advance to the next pattern.
- red  out  8  red pixel value.
- green  out  8  green pixel value.
- blue  out  8  blue pixel value.
- h_sync_out  out  1  hsync delayed to match RGB; active-low.
- v_sync_out  out  1  vsync delayed to match RGB; active-low.
- de_out  out  1  in_display delayed to match RGB.
- pattern_sel  out  2  currently applied pattern.
- frame_count  out  16  completed-frame counter; wraps at 65535 -> 0.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - RGB = 0, de_out = 0.
  - h_sync_out = 1, v_sync_out = 1 (inactive).
  - pattern_sel = 0, frame_count = 0, pending request = 0.
  - box_x = box_y = 0, direction = +x/+y.
- Reset mid-frame: everything returns to the reset values immediately. Output restarts cleanly from the next input sample.
- Pipeline: 2 stages, fixed latency of 2 clocks from inputs to all outputs.
  - Stage 1 registers x, y, de and both syncs, and the frame-start strobe fs = (counter_x==0 && counter_y==0).
  - Stage 2 computes and registers RGB.
  - Sync and de paths use the identical 2-register delay; polarity is preserved.
- Blanking: when the stage-1 de is 0, RGB = 0 regardless of pattern.
- Patterns, with x/y taken from stage 1:
  - 0 colour bars: bar = x[9:7]. The bar index gives {R,G,B} = {bar[2],bar[1],bar[0]}, each bit expanded to 8'hFF or 8'h00.
  - 1 checkerboard: x[5]^y[5] ? white : black.
  - 2 gradient: R = x[9:2], G = y[9:2], B = 8'h80.
  - 3 box: white where box_x <= x < box_x+BOX_SIZE and box_y <= y < box_y+BOX_SIZE, otherwise B = 8'hFF, R = G = 0. Comparisons use 11-bit arithmetic to avoid overflow.
- Pattern selection:
  - A pattern_next pulse sets pending.
  - On the cycle stage-1 fs = 1: if (pending | pattern_next), pattern_sel <= pattern_sel + 1 (3 wraps to 0), and pending is cleared.
  - Multiple pulses within one frame coalesce into a single advance.
  - A pulse coincident with fs applies at that frame start.
- Frame start: frame_count increments on each stage-1 fs.
- Box motion: box position updates on each stage-1 fs, in every pattern.
  - X axis: next = box_x ± BOX_STEP.
  - If next > H_ACTIVE-BOX_SIZE (or would go below 0), clamp to the bound and reverse x direction.
  - Y axis: same rule with V_ACTIVE.
  - Box position and pattern_sel are updated at fs, so the new values take effect for the whole following frame. The pixel (0,0) itself uses the updated values.

Optional Feature:
- Macro PATTERN_AUTO_CYCLE_EN.
- Defined:
  - A frame counter advances pattern_sel automatically every AUTO_FRAMES frame starts (counts 0..AUTO_FRAMES-1).
  - A manual advance at fs also restarts this counter at 0.
  - pattern_next still works.
- Undefined: no auto counter is present; only pattern_next changes the pattern.

Decomposition:
- Shared package hdmi_tester_pkg:
  - pattern enum (PAT_BARS = 0, PAT_CHECKER = 1, PAT_GRADIENT = 2, PAT_BOX = 3).
  - RGB struct/typedef.
  - Counter width constant (10).
- One sub-module: hdmi_box_mover, containing box position/direction registers and clamp/bounce logic. It is driven by fs and outputs box_x/box_y.

Test Plan:
- Reset, then counters sweep: pattern 0 at x=130, y=10, de=1 -> two clocks later R=00, G=00, B=FF. At x=900 -> R=G=B=FF.
- in_display=0 with h_sync_in=0 -> 2 clocks later RGB=0, h_sync_out=0, de_out=0. The sync edge is delayed exactly 2 clocks.
- pattern_next pulse at x=500, y=300 -> pattern_sel stays 0 until the next (0,0) sample, then becomes 1. Three pulses in one frame -> a single advance.
- Four frames of pattern_next -> pattern_sel sequence 1, 2, 3, 0 (wrap).
- Pattern 3, 470 frames -> box_x reaches 936 (H_ACTIVE-BOX_SIZE), then decreases to 934. Pixel (936,y in box) is white; (1000,y) is blanked.
- With PATTERN_AUTO_CYCLE_EN and AUTO_FRAMES=4 -> pattern_sel advances every 4 frame starts. Assert rst_n low mid-line -> all outputs go to reset values asynchronously.
